// File: rtl/mvau_sched.sv
// mvau_sched: issue scheduler for a matrix-vector activation unit.
// Each input vector arrives as SF words. During the first pass the words
// are streamed straight to mvau_stream and written into the input buffer.
// The remaining NF-1 passes replay the vector from that buffer. Every issue
// carries the matching weight tile address and the accumulator dump flags.
// Optional feature macro: MVAU_SCHED_PERF_EN adds a saturating 16-bit
// completed-vector counter on output vec_cnt.
module mvau_sched #(
  parameter int SF           = 4,
  parameter int NF           = 3,
  parameter int BUF_ADDR_BW  = (SF > 1) ? $clog2(SF) : 1,
  parameter int WMEM_ADDR_BW = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_v,
  output logic                    in_rdy,
  input  logic                    out_rdy,
  output logic                    buf_wr_en,
  output logic [BUF_ADDR_BW-1:0]  buf_wr_addr,
  output logic                    buf_rd_en,
  output logic [BUF_ADDR_BW-1:0]  buf_rd_addr,
  output logic                    strm_v,
  output logic                    sel_buf,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    sf_last,
  output logic                    nf_last
`ifdef MVAU_SCHED_PERF_EN
  ,
  output logic [15:0]             vec_cnt
`endif
);

  localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    REPLAY
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [BUF_ADDR_BW-1:0]  sf_reg;
  logic [NF_BW-1:0]        nf_reg;
  logic                    in_phase;
  logic                    issue;
  logic                    sf_wrap;
  logic                    nf_wrap;
  logic [WMEM_ADDR_BW-1:0] wmem_next;

  // Handshake, buffer port control and next-state decode for the current cycle.
  // rst_n gates the handshake so nothing is accepted while reset is held.
  always_comb begin
    in_phase    = (state_reg != REPLAY);
    in_rdy      = rst_n & out_rdy & in_phase;
    issue       = in_phase ? (in_v & in_rdy) : (rst_n & out_rdy);
    buf_wr_en   = in_phase & issue;
    buf_rd_en   = ~in_phase & issue;
    buf_wr_addr = sf_reg;
    buf_rd_addr = sf_reg;
    sf_wrap     = (sf_reg == BUF_ADDR_BW'(SF - 1));
    nf_wrap     = (nf_reg == NF_BW'(NF - 1));
    wmem_next   = WMEM_ADDR_BW'(32'(nf_reg) * 32'(SF) + 32'(sf_reg));
    state_next  = state_reg;
    if (sf_wrap && nf_wrap) begin
      state_next = IDLE;
    end else if (sf_wrap) begin
      state_next = REPLAY;
    end else if (state_reg == IDLE) begin
      state_next = FILL;
    end
  end

  // FSM, chunk/pass counters and the registered issue outputs; all advance only on an issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sf_reg    <= '0;
      nf_reg    <= '0;
      strm_v    <= 1'b0;
      sel_buf   <= 1'b0;
      wmem_addr <= '0;
      sf_last   <= 1'b0;
      nf_last   <= 1'b0;
    end else begin
      strm_v <= issue;
      if (issue) begin
        state_reg <= state_next;
        sf_reg    <= sf_wrap ? '0 : sf_reg + BUF_ADDR_BW'(1);
        if (sf_wrap) begin
          nf_reg <= nf_wrap ? '0 : nf_reg + NF_BW'(1);
        end
        sel_buf   <= ~in_phase;
        wmem_addr <= wmem_next;
        sf_last   <= sf_wrap;
        nf_last   <= nf_wrap;
      end
    end
  end

`ifdef MVAU_SCHED_PERF_EN
  // Count vectors that finish by leaving FILL or REPLAY for IDLE; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt <= 16'h0000;
    end else if (issue && sf_wrap && nf_wrap && (state_reg != IDLE) && (vec_cnt != 16'hFFFF)) begin
      vec_cnt <= vec_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_mvau_sched.sv
// tb_mvau_sched: self-checking bench for mvau_sched.
// Reference model tracks only the position k of the next issue inside the
// current vector (0 .. SF*NF-1); everything expected follows from k.
// Build with MVAU_SCHED_PERF_EN defined to also exercise vec_cnt.
module tb_mvau_sched;

  localparam int SF = 4;
  localparam int NF = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_v, out_rdy, in_rdy;
  logic       buf_wr_en, buf_rd_en, strm_v, sel_buf, sf_last, nf_last;
  logic [1:0] buf_wr_addr, buf_rd_addr;
  logic [3:0] wmem_addr;

  logic       in_v1, out_rdy1, in_rdy1;
  logic       buf_wr_en1, buf_rd_en1, strm_v1, sel_buf1, sf_last1, nf_last1;
  logic [0:0] buf_wr_addr1, buf_rd_addr1, wmem_addr1;
`ifdef MVAU_SCHED_PERF_EN
  logic [15:0] vec_cnt, vec_cnt1;
`endif

  int tests = 0;
  int fails = 0;

  // reference model state and expectations
  int k = 0;
  bit e_in_rdy, e_issue, e_wr, e_rd, e_strm, e_sel, e_sfl, e_nfl;
  int e_addr, e_wmem;

  mvau_sched #(.SF(SF), .NF(NF)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_rdy(in_rdy), .out_rdy(out_rdy),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .strm_v(strm_v), .sel_buf(sel_buf), .wmem_addr(wmem_addr),
    .sf_last(sf_last), .nf_last(nf_last)
`ifdef MVAU_SCHED_PERF_EN
    , .vec_cnt(vec_cnt)
`endif
  );

  mvau_sched #(.SF(1), .NF(1)) u_dut11 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v1), .in_rdy(in_rdy1), .out_rdy(out_rdy1),
    .buf_wr_en(buf_wr_en1), .buf_wr_addr(buf_wr_addr1),
    .buf_rd_en(buf_rd_en1), .buf_rd_addr(buf_rd_addr1),
    .strm_v(strm_v1), .sel_buf(sel_buf1), .wmem_addr(wmem_addr1),
    .sf_last(sf_last1), .nf_last(nf_last1)
`ifdef MVAU_SCHED_PERF_EN
    , .vec_cnt(vec_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs and derive the same-cycle expectations
  task automatic apply(input bit v, input bit r);
    @(negedge clk);
    in_v = v;
    out_rdy = r;
    #1;
    e_in_rdy = (k < SF) ? r : 1'b0;
    e_issue  = (k < SF) ? (v && r) : r;
    e_wr     = (k < SF) && e_issue;
    e_rd     = (k >= SF) && e_issue;
    e_addr   = k % SF;
  endtask

  // cross the clock edge and derive expectations for the registered outputs
  task automatic advance();
    @(posedge clk);
    #1;
    e_strm = e_issue;
    if (e_issue) begin
      e_wmem = k;
      e_sel  = (k >= SF);
      e_sfl  = ((k % SF) == SF - 1);
      e_nfl  = ((k / SF) == NF - 1);
      k = (k + 1) % (SF * NF);
    end
  endtask

  task automatic test_reset();
    logic [14:0] snap;
    rst_n = 1'b0; in_v = 1'b1; out_rdy = 1'b1; in_v1 = 1'b0; out_rdy1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    snap = {in_rdy, strm_v, buf_wr_en, buf_rd_en, sel_buf, sf_last, nf_last,
            buf_wr_addr, buf_rd_addr, wmem_addr};
    tests++;
    if (snap !== 15'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp 0000", snap);
    end
    in_v = 1'b0;
    rst_n = 1'b1;
    k = 0;
    $display("[TB] reset released");
  endtask

  task automatic test_back_to_back();
    int strm_cnt = 0;
    int rdy_low = 0;
    for (int i = 0; i < SF * NF; i++) begin
      apply(i < SF, 1'b1);
      if (in_rdy == 1'b0) rdy_low++;
      tests++;
      if (in_rdy !== e_in_rdy) begin
        fails++;
        $display("FAIL b2b_in_rdy cycle %0d got %b exp %b", i, in_rdy, e_in_rdy);
      end
      advance();
      if (strm_v === 1'b1) strm_cnt++;
      tests++;
      if (strm_v !== e_strm || int'(wmem_addr) !== e_wmem || sel_buf !== e_sel) begin
        fails++;
        $display("FAIL b2b_issue cycle %0d got v=%b wmem=%0d sel=%b exp v=%b wmem=%0d sel=%b",
                 i, strm_v, wmem_addr, sel_buf, e_strm, e_wmem, e_sel);
      end
      $display("[TB] b2b issue wmem=%0d sel=%b", wmem_addr, sel_buf);
    end
    tests++;
    if (strm_cnt !== 12 || rdy_low !== 8) begin
      fails++;
      $display("FAIL b2b_counts got strm=%0d rdy_low=%0d exp strm=12 rdy_low=8", strm_cnt, rdy_low);
    end
  endtask

  task automatic test_stall();
    int gap = 0;
    int resume_wmem = -1;
    for (int i = 0; i < 15; i++) begin
      bit stall;
      stall = (i >= 6 && i < 9);
      apply((i < SF) || stall, !stall);
      tests++;
      if (buf_rd_en !== e_rd || buf_wr_en !== e_wr || (e_rd && int'(buf_rd_addr) !== e_addr)) begin
        fails++;
        $display("FAIL stall_buf cycle %0d got rd=%b wr=%b addr=%0d exp rd=%b wr=%b addr=%0d",
                 i, buf_rd_en, buf_wr_en, buf_rd_addr, e_rd, e_wr, e_addr);
      end
      advance();
      if (stall && strm_v === 1'b0) gap++;
      if (i == 9) resume_wmem = int'(wmem_addr);
      tests++;
      if (strm_v !== e_strm || (e_strm && int'(wmem_addr) !== e_wmem)) begin
        fails++;
        $display("FAIL stall_issue cycle %0d got v=%b wmem=%0d exp v=%b wmem=%0d",
                 i, strm_v, wmem_addr, e_strm, e_wmem);
      end
      $display("[TB] stall cycle %0d strm_v=%b wmem=%0d", i, strm_v, wmem_addr);
    end
    tests++;
    if (gap !== 3 || resume_wmem !== 6) begin
      fails++;
      $display("FAIL stall_gap got gap=%0d resume=%0d exp gap=3 resume=6", gap, resume_wmem);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] snap;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 1'b1);
      advance();
    end
    @(negedge clk);
    #2;
    in_v = 1'b1; out_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    snap = {in_rdy, strm_v, buf_wr_en, buf_rd_en, sel_buf, sf_last, nf_last,
            buf_wr_addr, buf_rd_addr, wmem_addr};
    tests++;
    if (snap !== 15'h0) begin
      fails++;
      $display("FAIL async_reset_outputs got %h exp 0000", snap);
    end
    @(negedge clk);
    in_v = 1'b0;
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < SF * NF; i++) begin
      apply(i < SF, 1'b1);
      advance();
      tests++;
      if (strm_v !== e_strm || int'(wmem_addr) !== e_wmem || sel_buf !== e_sel) begin
        fails++;
        $display("FAIL after_reset_issue cycle %0d got v=%b wmem=%0d sel=%b exp v=%b wmem=%0d sel=%b",
                 i, strm_v, wmem_addr, sel_buf, e_strm, e_wmem, e_sel);
      end
      $display("[TB] post-reset issue wmem=%0d sel=%b", wmem_addr, sel_buf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      tests++;
      if (in_rdy !== e_in_rdy || buf_wr_en !== e_wr || buf_rd_en !== e_rd ||
          (e_wr && int'(buf_wr_addr) !== e_addr) || (e_rd && int'(buf_rd_addr) !== e_addr)) begin
        fails++;
        $display("FAIL rand_comb cycle %0d got rdy=%b wr=%b rd=%b wa=%0d ra=%0d exp rdy=%b wr=%b rd=%b addr=%0d",
                 i, in_rdy, buf_wr_en, buf_rd_en, buf_wr_addr, buf_rd_addr, e_in_rdy, e_wr, e_rd, e_addr);
      end
      advance();
      tests++;
      if (strm_v !== e_strm || (e_strm && (int'(wmem_addr) !== e_wmem || sel_buf !== e_sel ||
          sf_last !== e_sfl || nf_last !== e_nfl))) begin
        fails++;
        $display("FAIL rand_issue cycle %0d got v=%b wmem=%0d sel=%b sfl=%b nfl=%b exp v=%b wmem=%0d sel=%b sfl=%b nfl=%b",
                 i, strm_v, wmem_addr, sel_buf, sf_last, nf_last, e_strm, e_wmem, e_sel, e_sfl, e_nfl);
      end
      if (strm_v === 1'b1)
        $display("[TB] rand issue wmem=%0d sel=%b sfl=%b nfl=%b", wmem_addr, sel_buf, sf_last, nf_last);
    end
  endtask

  task automatic test_sf1();
    int pulses = 0;
    in_v = 1'b0; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int idle;
      idle = $urandom_range(0, 2);
      repeat (idle) begin
        @(negedge clk);
        in_v1 = 1'b0; out_rdy1 = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (strm_v1 !== 1'b0) begin
          fails++;
          $display("FAIL sf1_idle got strm_v=%b exp 0", strm_v1);
        end
      end
      @(negedge clk);
      in_v1 = 1'b1; out_rdy1 = 1'b1;
      #1;
      tests++;
      if (in_rdy1 !== 1'b1) begin
        fails++;
        $display("FAIL sf1_in_rdy beat %0d got %b exp 1", i, in_rdy1);
      end
      @(posedge clk);
      #1;
      if (strm_v1 === 1'b1) pulses++;
      tests++;
      if (strm_v1 !== 1'b1 || wmem_addr1 !== 1'b0 || sf_last1 !== 1'b1 || nf_last1 !== 1'b1) begin
        fails++;
        $display("FAIL sf1_issue beat %0d got v=%b wmem=%0d sfl=%b nfl=%b exp v=1 wmem=0 sfl=1 nfl=1",
                 i, strm_v1, wmem_addr1, sf_last1, nf_last1);
      end
      $display("[TB] sf1 issue beat %0d wmem=%0d", i, wmem_addr1);
    end
    @(negedge clk);
    in_v1 = 1'b0; out_rdy1 = 1'b0;
    tests++;
    if (pulses !== 5) begin
      fails++;
      $display("FAIL sf1_pulses got %0d exp 5", pulses);
    end
  endtask

`ifdef MVAU_SCHED_PERF_EN
  task automatic test_perf();
    int issued = 0;
    @(negedge clk);
    in_v = 1'b0; out_rdy = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    tests++;
    if (vec_cnt !== 16'd0) begin
      fails++;
      $display("FAIL perf_reset got %0d exp 0", vec_cnt);
    end
    for (int i = 0; i < 2000 && issued < 3 * SF * NF; i++) begin
      apply(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      advance();
      if (e_strm) begin
        issued++;
        tests++;
        if (strm_v !== 1'b1 || int'(wmem_addr) !== e_wmem || sf_last !== e_sfl) begin
          fails++;
          $display("FAIL perf_issue got v=%b wmem=%0d sfl=%b exp v=1 wmem=%0d sfl=%b",
                   strm_v, wmem_addr, sf_last, e_wmem, e_sfl);
        end
        $display("[TB] perf issue wmem=%0d sfl=%b", wmem_addr, sf_last);
      end
    end
    @(negedge clk);
    in_v = 1'b0; out_rdy = 1'b0;
    #1;
    tests++;
    if (vec_cnt !== 16'd3 || issued !== 3 * SF * NF) begin
      fails++;
      $display("FAIL perf_vec_cnt got %0d (issued %0d) exp 3 (issued 36)", vec_cnt, issued);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_random();
    test_sf1();
`ifdef MVAU_SCHED_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mvau_sched.md
MVAU_SCHED -- requirements
Module: mvau_sched

Interface
REQ-001 Parameter SF, default 4, SIMD chunks per input vector (number of words per vector); SF >= 1.
REQ-002 Parameter NF, default 3, PE row-groups, i.e. passes over each vector; NF >= 1.
REQ-003 Parameter BUF_ADDR_BW, default $clog2(SF) with a minimum of 1, input-buffer address width.
REQ-004 Parameter WMEM_ADDR_BW, default $clog2(SF*NF) with a minimum of 1, weight-memory address width.
REQ-005 Port clk, input, 1, main clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1, active-low reset, asynchronous assertion.
REQ-007 Port in_v, input, 1, upstream activation word valid.
REQ-008 Port in_rdy, output, 1, scheduler accepts an activation word this cycle.
REQ-009 Port out_rdy, input, 1, downstream (mvau_stream) can take an issue this cycle.
REQ-010 Port buf_wr_en, output, 1, write the current input word into the buffer.
REQ-011 Port buf_wr_addr, output, BUF_ADDR_BW, buffer write address.
REQ-012 Port buf_rd_en, output, 1, synchronous buffer read request (1-cycle read latency).
REQ-013 Port buf_rd_addr, output, BUF_ADDR_BW, buffer read address.
REQ-014 Port strm_v, output, 1, activation/weight tile valid to mvau_stream.
REQ-015 Port sel_buf, output, 1, datapath mux select: 0 = registered input word, 1 = buffer read data.
REQ-016 Port wmem_addr, output, WMEM_ADDR_BW, weight tile address.
REQ-017 Port sf_last, output, 1, the issued word is chunk SF-1 (accumulator dump).
REQ-018 Port nf_last, output, 1, the issued word belongs to pass NF-1.

Function
REQ-019 The block SHALL hold state in FSM {IDLE, FILL, REPLAY} plus counters sf (0..SF-1) and nf (0..NF-1).
REQ-020 in_rdy SHALL equal out_rdy while in IDLE or FILL, and 0 while in REPLAY.
REQ-021 An issue SHALL occur on a cycle where, in IDLE/FILL, in_v && in_rdy holds, or, in REPLAY, out_rdy holds.
REQ-022 On a FILL-type issue (IDLE/FILL), in the same cycle: buf_wr_en = 1 and buf_wr_addr = sf; in the cycle after: strm_v = 1, sel_buf = 0.
REQ-023 On a REPLAY issue, in the same cycle: buf_rd_en = 1 and buf_rd_addr = sf; in the cycle after: strm_v = 1, sel_buf = 1.
REQ-024 In the cycle after any issue: wmem_addr = nf*SF + sf, and sf_last and nf_last reflect the issuing counters.
REQ-025 strm_v SHALL be 0 in every cycle that does not follow an issue.
REQ-026 On each issue, sf SHALL increment, wrapping to 0 after SF-1; on that wrap, nf SHALL increment, wrapping to 0 after NF-1.
REQ-027 Transitions: IDLE->FILL on the first issue when SF > 1.
REQ-028 Transition: FILL->REPLAY on the issue with sf = SF-1 when NF > 1.
REQ-029 Transition: REPLAY->IDLE on the issue with sf = SF-1 and nf = NF-1.
REQ-030 Transition: FILL->IDLE on the issue with sf = SF-1 when NF = 1.
REQ-031 When SF = 1, an IDLE issue SHALL go directly to REPLAY, or stay in IDLE if NF = 1.
REQ-032 When out_rdy = 0, no issue SHALL occur, all counters and the state SHALL hold, and in_v SHALL be ignored.
REQ-033 buf_wr_en and buf_rd_en SHALL never both be asserted in the same cycle.

Reset
REQ-034 On assertion of rst_n = 0, the block SHALL asynchronously force: state = IDLE, sf = nf = 0, in_rdy = 0, strm_v = 0, buf_wr_en = 0, buf_rd_en = 0, sel_buf = 0, all addresses = 0, sf_last = 0, nf_last = 0.
REQ-035 Reset asserted mid-vector SHALL discard the partial vector; the first issue after release SHALL be wmem_addr 0.

Configuration
REQ-036 Macro MVAU_SCHED_PERF_EN: when defined, add output port vec_cnt (16 bits), reset to 0, incremented on each REPLAY->IDLE or FILL->IDLE transition, saturating at 16'hFFFF; when undefined, no such port and no counter logic.

Verification
REQ-037 Scenario (SF=4, NF=3): 4 back-to-back in_v beats with out_rdy = 1 -> 12 consecutive strm_v cycles; wmem_addr 0..11; sel_buf = 0 for the first 4, 1 for the rest; in_rdy = 0 for 8 cycles.
REQ-038 Scenario (SF=4, NF=3): out_rdy = 0 for 3 cycles mid-REPLAY at nf=1, sf=2 -> strm_v gap of 3 cycles; resume at wmem_addr 6 with no skip or repeat.
REQ-039 Scenario (SF=1, NF=1): 5 beats -> 5 strm_v pulses; each has wmem_addr 0 and sf_last = nf_last = 1; in_rdy never drops while out_rdy = 1.
REQ-040 Scenario (SF=4, NF=3): rst_n pulsed low asynchronously at nf=1 -> all outputs 0 immediately; next vector starts at wmem_addr 0, sel_buf = 0.
REQ-041 Scenario (SF=4, NF=3, MVAU_SCHED_PERF_EN defined): 3 vectors -> vec_cnt = 3; sf_last asserted on wmem_addr 3, 7, 11 only.
